// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Decode helpers turn one-low nibbles into a 2-bit index.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } row_hit_t;

   // A hit requires exactly one low row; ghosting patterns with two or more low rows are rejected.
   function automatic row_hit_t decode_rows(input logic [3:0] rs);
      row_hit_t r;
      r.hit = 1'b1;
      r.idx = 2'd0;
      case (rs)
         4'b1110: r.idx = 2'd0;
         4'b1101: r.idx = 2'd1;
         4'b1011: r.idx = 2'd2;
         4'b0111: r.idx = 2'd3;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] cols);
      logic [1:0] idx;
      idx = 2'd0;
      case (cols)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-idle so no phantom key is seen coming out of reset.
module keypad_row_sync
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows_in,
   output logic [3:0] rows_sync
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;
   logic [3:0] meta_d;
   logic [3:0] sync_d;

   always_comb begin
      meta_d = rows_in;
      sync_d = meta_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= ROWS_IDLE;
         sync_q <= ROWS_IDLE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign rows_sync = sync_q;

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner with per-key debounce; each accepted key is
// shifted as one hex digit into a 16-bit entry value.
module keypad_hex_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_BITS  = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rows,
   output logic [3:0]  cols,
   input  logic        clear,
   output logic [3:0]  key_code,
   output logic        key_strobe,
   output logic [15:0] value
);

   localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

   logic [3:0] rs;

   keypad_row_sync u_row_sync (
      .clk      (clk),
      .rst      (rst),
      .rows_in  (rows),
      .rows_sync(rs)
   );

   logic [SCAN_DIV_BITS-1:0] div_q, div_d;
   state_t                   state_q, state_d;
   logic [3:0]               cols_q, cols_d;
   logic [3:0]               cand_q, cand_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [3:0]               key_code_q, key_code_d;
   logic                     key_strobe_q, key_strobe_d;
   logic [15:0]              value_q, value_d;

   logic       tick;
   logic       accept;
   row_hit_t   row_hit;
   logic [3:0] code;

   // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
   always_comb begin
      div_d        = div_q + SCAN_DIV_BITS'(1);
      tick         = &div_q;
      state_d      = state_q;
      cols_d       = cols_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      key_code_d   = key_code_q;
      key_strobe_d = 1'b0;
      value_d      = value_q;
      accept       = 1'b0;
      row_hit      = decode_rows(rs);
      code         = {row_hit.idx, col_index(cols_q)};

      if (tick) begin
         case (state_q)
            SCAN: begin
               if (row_hit.hit) begin
                  cand_d  = code;
                  cnt_d   = 4'd1;
                  state_d = DEBOUNCE;
               end else begin
                  cols_d = {cols_q[2:0], cols_q[3]};
               end
            end
            DEBOUNCE: begin
               if (row_hit.hit && code == cand_q) begin
                  if (cnt_q + 4'd1 == DEB_TARGET) begin
                     accept  = 1'b1;
                     cnt_d   = 4'd0;
                     state_d = HELD;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = SCAN;
               end
            end
            HELD: begin
               if (rs == ROWS_IDLE) begin
                  cnt_d   = 4'd1;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (rs == ROWS_IDLE) begin
                  if (cnt_q + 4'd1 == DEB_TARGET) begin
                     cnt_d   = 4'd0;
                     state_d = SCAN;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = HELD;
               end
            end
            default: begin
               cnt_d   = 4'd0;
               state_d = SCAN;
            end
         endcase
      end

      if (accept) begin
         key_strobe_d = 1'b1;
         key_code_d   = cand_q;
         value_d      = {value_q[11:0], cand_q};
      end

      // Clear overrides a coinciding accept for the entry value only.
      if (clear) begin
         value_d = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         state_q      <= SCAN;
         cols_q       <= COL_RESET;
         cand_q       <= 4'd0;
         cnt_q        <= 4'd0;
         key_code_q   <= 4'd0;
         key_strobe_q <= 1'b0;
         value_q      <= 16'h0000;
      end else begin
         div_q        <= div_d;
         state_q      <= state_d;
         cols_q       <= cols_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         key_code_q   <= key_code_d;
         key_strobe_q <= key_strobe_d;
         value_q      <= value_d;
      end
   end

   assign cols       = cols_q;
   assign key_code   = key_code_q;
   assign key_strobe = key_strobe_q;
   assign value      = value_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench: stimulus pushes expected {code, value} per accepted key,
// a negedge monitor pops and compares whenever key_strobe is seen.
module tb_keypad_hex_entry;

   localparam int DIV   = 2;
   localparam int D     = 3;
   localparam int TICK  = 1 << DIV;
   localparam int LAT_MAX = (4 + D) * TICK + 3 + 2;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] value;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        clear = 1'b0;
   logic [3:0]  key_code;
   logic        key_strobe;
   logic [15:0] value;

   logic [15:0] pressed = 16'h0000;
   logic [15:0] model_value = 16'h0000;
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          strobe_cnt = 0;
   logic        prev_strobe = 1'b0;

   keypad_hex_entry #(
      .SCAN_DIV_BITS (DIV),
      .DEBOUNCE_SCANS(D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rows      (rows),
      .cols      (cols),
      .clear     (clear),
      .key_code  (key_code),
      .key_strobe(key_strobe),
      .value     (value)
   );

   always #5 clk = ~clk;

   // Keypad: row r is pulled low while column c is driven low and key {r,c} is down.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("cols_one_low", 32'($countones(~cols)), 32'd1);
         if (key_strobe) begin
            strobe_cnt++;
            check("strobe_not_back_to_back", 32'(prev_strobe), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got code %0h value %0h, expected no strobe", key_code, value);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("strobe_code", 32'(key_code), 32'(e.code));
               check("strobe_value", 32'(value), 32'(e.value));
            end
         end
      end
      prev_strobe = key_strobe;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_t e;
      model_value = {model_value[11:0], code};
      e.code  = code;
      e.value = model_value;
      exp_q.push_back(e);
   endtask

   task automatic wait_strobe(input string name, input int start);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LAT_MAX && !seen; i++) begin
         clocks(1);
         if (strobe_cnt != start) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic press_key(input logic [3:0] code, input int hold_ticks);
      int start;
      expect_key(code);
      start = strobe_cnt;
      pressed[code] = 1'b1;
      wait_strobe("press_latency", start);
      clocks(hold_ticks * TICK);
      pressed[code] = 1'b0;
      clocks((D + 2) * TICK);
   endtask

   task automatic wait_cols(input logic [3:0] target, input bit want_eq);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8 * TICK && !ok; i++) begin
         clocks(1);
         if ((cols == target) == want_eq) ok = 1'b1;
      end
      check("cols_wait", 32'(ok), 32'd1);
   endtask

   task automatic check_rotating(input string name, input int nticks);
      logic [3:0] prev;
      bit         moved;
      prev  = cols;
      moved = 1'b0;
      for (int i = 0; i < 8 * TICK && !moved; i++) begin
         clocks(1);
         if (cols != prev) moved = 1'b1;
      end
      check({name, "_moved"}, 32'(moved), 32'd1);
      for (int t = 0; t < nticks; t++) begin
         prev = cols;
         clocks(TICK);
         check(name, 32'(cols), 32'({prev[2:0], prev[3]}));
      end
   endtask

   initial begin
      int start;

      // Reset state
      clocks(2);
      check("rst_cols", 32'(cols), 32'h0000_000E);
      check("rst_strobe", 32'(key_strobe), 32'd0);
      rst = 1'b0;
      clocks(1);
      check("post_rst_cols", 32'(cols), 32'h0000_000E);
      check("post_rst_code", 32'(key_code), 32'd0);
      check("post_rst_value", 32'(value), 32'd0);

      // Single key
      start = strobe_cnt;
      press_key(4'h5, 30);
      check("single_count", 32'(strobe_cnt - start), 32'd1);
      check("single_code", 32'(key_code), 32'h5);
      check("single_value", 32'(value), 32'h0005);

      // Digit entry
      start = strobe_cnt;
      press_key(4'h1, 2);
      press_key(4'h2, 0);
      press_key(4'h3, 5);
      press_key(4'h4, 1);
      check("entry_count", 32'(strobe_cnt - start), 32'd4);
      check("entry_1234", 32'(value), 32'h1234);
      press_key(4'hA, 3);
      check("entry_234A", 32'(value), 32'h234A);

      // Bounce on key 2 (row 0, column 2)
      start = strobe_cnt;
      for (int t = 0; t < 10; t++) begin
         pressed[2] = ~pressed[2];
         clocks(TICK);
      end
      pressed[2] = 1'b0;
      check("bounce_no_strobe", 32'(strobe_cnt - start), 32'd0);
      check_rotating("bounce_rotate", 4);

      // Long hold of F, then 7 (same column) pressed while F still held
      start = strobe_cnt;
      expect_key(4'hF);
      pressed[15] = 1'b1;
      wait_strobe("hold_latency", start);
      clocks(200 * TICK);
      pressed[7] = 1'b1;
      clocks(20 * TICK);
      pressed[15] = 1'b0;
      clocks(5 * TICK);
      pressed[7] = 1'b0;
      clocks((D + 2) * TICK);
      check("hold_one_strobe", 32'(strobe_cnt - start), 32'd1);
      check("hold_code", 32'(key_code), 32'hF);
      press_key(4'h7, 2);
      check("rollover_code", 32'(key_code), 32'h7);

      // Two keys in column 1 (rows 0 and 2): ghost pattern, stays in SCAN
      start = strobe_cnt;
      pressed[1] = 1'b1;
      pressed[9] = 1'b1;
      check_rotating("illegal_rotate", 8);
      pressed[1] = 1'b0;
      pressed[9] = 1'b0;
      clocks(2 * TICK);
      check("illegal_no_strobe", 32'(strobe_cnt - start), 32'd0);

      // Clear on the accept edge of key 9: column 1 becomes driven at edge T,
      // detection at T+4, accept at T+12.
      wait_cols(4'b1101, 1'b0);
      pressed[9] = 1'b1;
      wait_cols(4'b1101, 1'b1);
      model_value = 16'h0000;
      begin
         exp_t e;
         e.code  = 4'h9;
         e.value = 16'h0000;
         exp_q.push_back(e);
      end
      clocks(11);
      clear = 1'b1;
      clocks(1);
      clear = 1'b0;
      check("clear_win_strobe", 32'(key_strobe), 32'd1);
      check("clear_win_value", 32'(value), 32'd0);
      check("clear_win_code", 32'(key_code), 32'h9);
      clocks(TICK);
      pressed[9] = 1'b0;
      clocks((D + 2) * TICK);

      press_key(4'h5, 1);
      check("pre_rst_value", 32'(value), 32'h0005);

      // Reset mid-DEBOUNCE on key 6 (row 1, column 2)
      wait_cols(4'b1011, 1'b0);
      pressed[6] = 1'b1;
      wait_cols(4'b1011, 1'b1);
      clocks(5);
      rst = 1'b1;
      clocks(1);
      rst = 1'b0;
      pressed[6] = 1'b0;
      model_value = 16'h0000;
      check("mid_rst_cols", 32'(cols), 32'h0000_000E);
      check("mid_rst_value", 32'(value), 32'd0);
      check("mid_rst_strobe", 32'(key_strobe), 32'd0);
      clocks(1);
      check("mid_rst_strobe_next", 32'(key_strobe), 32'd0);
      clocks(4 * TICK);

      // Randomized entry with occasional clears
      for (int k = 0; k < 12; k++) begin
         clocks($urandom_range(0, 7));
         press_key(4'($urandom_range(0, 15)), $urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) begin
            clear = 1'b1;
            clocks(1);
            clear = 1'b0;
            model_value = 16'h0000;
            check("rand_clear", 32'(value), 32'd0);
         end
         check("rand_value", 32'(value), 32'(model_value));
      end

      clocks(2);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
